// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first with one full-subtractor cell
// and a registered borrow; operands and results move over valid/ready handshakes.
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [1:0]       sub_s;

    // Returns {borrow_next, difference_bit}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bin);
        logic d_bit;
        logic b_next;
        d_bit  = ai ^ bi ^ bin;
        b_next = (~ai & bi) | (~(ai ^ bi) & bin);
        return {b_next, d_bit};
    endfunction

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sub_s   = full_sub(a_q[0], b_q[0], br_q);

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    diff_d  = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Operands shift right so the active bit is always at index 0;
                // result bits enter at the MSB and end up LSB-aligned.
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                br_d   = sub_s[1];
                diff_d = {sub_s[0], diff_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    bout_d  = sub_s[1];
                    ovf_d   = (a_msb_q ^ b_msb_q) & (sub_s[0] ^ a_msb_q);
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign diff        = diff_q;
    assign borrow_out  = bout_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench for bit_serial_subtractor: a driver pushes expected results on
// each accepted start; a negedge monitor pops and compares on each result handshake.
module tb_bit_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           sc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         done_valid;
    logic         done_ready = 1'b1;
    logic         busy;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic prev_dv = 1'b0;
    exp_t sb[$];

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b),
        .diff(diff), .borrow_out(borrow_out), .overflow(overflow),
        .done_valid(done_valid), .done_ready(done_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out, expected an event", nm);
    endfunction

    // Monitor: latency on the rising done_valid, result fields on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_dv = 1'b0;
        end else begin
            if (done_valid && !prev_dv && sb.size() > 0)
                chk("latency", cyc - sb[0].sc, W);
            if (done_valid && done_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got diff=%0h, expected no result", diff);
                end else begin
                    e = sb.pop_front();
                    chk("diff", diff, e.d);
                    chk("borrow_out", borrow_out, e.bo);
                    chk("overflow", overflow, e.ov);
                end
            end
            prev_dv = done_valid;
        end
    end

    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input bit keep, output int acc_cyc);
        exp_t e;
        bit   got;
        got = 1'b0;
        acc_cyc = 0;
        a = aa;
        b = bb;
        start_valid = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (start_ready) begin
                got = 1'b1;
                e.d = ed; e.bo = eb; e.ov = eo; e.sc = cyc + 1;
                acc_cyc = cyc + 1;
                sb.push_back(e);
            end
        end
        if (!got) timeout("start_accept");
        @(posedge clk);
        #1;
        if (!keep) start_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || done_valid) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           acc;
        int           prev_acc;
        int           k;
        logic [W-1:0] ra, rb, rd;
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        logic [W-1:0] vd[3];
        logic         vbo[3];

        // Reset state
        #12;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, hand-computed results
        issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, acc); wait_idle();
        issue(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, acc); wait_idle();
        issue(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, acc); wait_idle();
        issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, acc); wait_idle();
        issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, acc); wait_idle();

        // Backpressure with stray start pulses during SHIFT and DONE
        done_ready = 1'b0;
        issue(8'h40, 8'h10, 8'h30, 1'b0, 1'b0, 1'b0, acc);
        a = 8'h11; b = 8'h00; start_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_valid = 1'b0;
        k = 0;
        while (!done_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!done_valid) timeout("bp_done_valid");
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_diff", diff, 8'h30);
            chk("bp_borrow", borrow_out, 0);
            chk("bp_overflow", overflow, 0);
            chk("bp_done_valid", done_valid, 1);
            chk("bp_start_ready", start_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        done_ready = 1'b1;
        wait_idle();

        // Asynchronous reset in the middle of SHIFT
        issue(8'h55, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, acc);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_borrow", borrow_out, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_done_valid", done_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start_ready", start_ready, 1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, acc); wait_idle();

        // Back-to-back with start_valid held high
        va[0] = 8'h10; vb[0] = 8'h01; vd[0] = 8'h0F; vbo[0] = 1'b0;
        va[1] = 8'h01; vb[1] = 8'h10; vd[1] = 8'hF1; vbo[1] = 1'b1;
        va[2] = 8'hC0; vb[2] = 8'h40; vd[2] = 8'h80; vbo[2] = 1'b0;
        prev_acc = 0;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i], vd[i], vbo[i], 1'b0, 1'b1, acc);
            if (i > 0) chk("b2b_spacing_ok", ((acc - prev_acc) >= W + 1), 1);
            prev_acc = acc;
        end
        start_valid = 1'b0;
        wait_idle();

        // 200 random pairs, back-to-back, against a reference subtract
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rd = ra - rb;
            issue(ra, rb, rd, (ra < rb),
                  ((ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1])), 1'b1, acc);
        end
        start_valid = 1'b0;
        wait_idle();

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
